tile_line_fetcher: RTL
======================

Name: tile_line_fetcher

Overview:
- Read-side consumer of the tile memories. Host writes tile_buffer, tile_graphics and color_palettes; this block reads them back for one scanline.
- Walks one scanline: tile-map lookup, then tile row words, then palette lookup.
- Streams 640 24-bit RGB pixels over a valid/ready interface into the downstream line buffer / sprite compositor.
- Drives only read addresses; integration holds memory rw=0 while busy=1.

Parameters:
- TILES_X, 20: tiles per line (tile_buffer row pitch).
- LINES, 480: visible lines; line_num >= LINES is rejected.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- line_start  in  1  single-cycle request to fetch line line_num
- line_num  in  9  scanline 0..LINES-1
- busy  out  1  fetch in progress
- tb_addr  out  9  tile_buffer read address
- tb_rdata  in  32  tile_buffer read data (registered, 1-cycle latency)
- tg_addr  out  11  tile_graphics read address
- tg_rdata  in  32  tile_graphics read data (1-cycle latency)
- pal_addr  out  3  color_palettes read address
- pal_rdata  in  24  palette RGB (1-cycle latency)
- pix_valid  out  1  pixel presented
- pix_ready  in  1  downstream accepts pixel
- pix_rgb  out  24  pixel colour
- pix_x  out  10  pixel column 0..639
- pix_transp  out  1  pixel nibble bit 3 (transparent flag)
- pix_last  out  1  high with pix_x==639

Behaviour:
- Reset (async) clears all outputs and addresses to 0 and forces state IDLE. Reset mid-line abandons the line; no partial stream resumes.
- Reset mid-line with pix_valid=1: pix_valid drops immediately.
- line_start is accepted only in IDLE with line_num < LINES. Otherwise it is ignored; busy stays 0 for out-of-range.
- Decode: tile_row = line_num[8:5], row_in_tile = line_num[4:0].
- tb_addr = tile_row*TILES_X + col, with col 0..TILES_X-1.
- Tile entry: tile_id = tb_rdata[3:0]; bits 31:4 ignored.
- tg_addr = {tile_id, row_in_tile, word[1:0]}: 4 words (32 px) per tile row.
- Word pixel order: nibble 0 (bits 3:0) is leftmost. pal_addr = nibble[2:0]; pix_transp = nibble[3].
- FSM:
  - IDLE -> TB_ADDR on accept.
  - TB_ADDR (drive tb_addr) -> TB_DATA (capture tile_id).
  - TB_DATA -> TG_ADDR -> TG_DATA (capture word) -> PIX.
  - PIX issues 8 palette reads.
  - After PIX: word<3 -> TG_ADDR with word+1; else col<TILES_X-1 -> TB_ADDR with col+1, word=0; else DRAIN.
  - DRAIN -> IDLE once the last pixel is accepted.
- Palette pipeline:
  - One read in flight. pal_rdata is loaded into the pix_rgb register when the output is empty or accepted that cycle; pal_addr then advances.
  - If the output is stalled (pix_valid & !pix_ready), pal_addr holds, so pal_rdata stays valid.
  - Gives 1 pixel/cycle with pix_ready=1.
- Latency: line_start in cycle 0 -> first pix_valid in cycle 7 (pix_ready=1).
- Stream: pix_x increments per accepted pixel. pix_rgb, pix_x, pix_transp and pix_last are stable while pix_valid & !pix_ready.
- busy: 1 from cycle after accept until cycle after pix_last accepted. With pix_ready=1 a line completes in <= 1000 cycles.
- Simultaneous: line_start on the cycle busy falls is ignored. The next request needs busy=0 at sampling.

Optional Feature:
- Macro TILE_HFLIP_EN.
- Defined: tb_rdata[4] = horizontal flip for that tile.
  - Word order is 3..0.
  - Nibble order is 7..0 within each word.
  - pix_x still increases monotonically.
- Undefined: bit 4 ignored; no flip logic is instantiated.

Test Plan:
- Tile map all tile_id=2, tile_graphics row words 0x76543210, palette[i]=0x0000i0, line_num=0, pix_ready=1 -> pixels repeat 0x000000..0x000070 across all 640, pix_last at x=639, first pix_valid 7 cycles after line_start.
- line_num=37 -> tb_addr sequence 20..39, tg_addr = {id,5'd5,word}; tile_buffer[25]=id 9 -> pixels 160..191 come from tile 9 row 5.
- Random pix_ready (50%) -> accepted pixel sequence identical to the pix_ready=1 run; outputs stable during every stall.
- Nibble 0xF -> pal_addr=7, pix_transp=1; nibble 0x7 -> pix_transp=0.
- line_start while busy, and line_num=480 -> both ignored, no extra pixels. Reset asserted at pixel 300 -> busy=0, pix_valid=0 immediately; a new line then starts cleanly at x=0.
- TILE_HFLIP_EN defined, tile entry 0x12, row word0=0x00000001, others 0 -> pixel x=31 of that tile uses palette 1, x=0 uses palette 0.

Source files
------------

// File: rtl/tile_line_fetcher.sv
// Scanline fetcher: tile map -> tile row words -> palette, streamed as 24-bit RGB pixels.
// Optional per-tile horizontal flip (tile entry bit 4) is built in when TILE_HFLIP_EN is defined.
module tile_line_fetcher #(
  parameter int unsigned TILES_X = 20,
  parameter int unsigned LINES   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  line_num,
  output logic        busy,
  output logic [8:0]  tb_addr,
  input  logic [31:0] tb_rdata,
  output logic [10:0] tg_addr,
  input  logic [31:0] tg_rdata,
  output logic [2:0]  pal_addr,
  input  logic [23:0] pal_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic [9:0]  pix_x,
  output logic        pix_transp,
  output logic        pix_last
);

  localparam int unsigned LastX = TILES_X * 32 - 1;

  typedef enum logic [2:0] {
    StIdle, StTbAddr, StTbData, StTgAddr, StTgData, StPix, StDrain
  } state_e;

  state_e      state_q;
  logic [4:0]  row_q;
  logic [4:0]  col_q;
  logic [1:0]  word_idx_q;
  logic [3:0]  tile_id_q;
  logic [31:0] word_q;
  logic [2:0]  nib_idx_q;
  logic        b_vld_q;
  logic [2:0]  b_addr_q;
  logic        b_transp_q;
  logic [9:0]  out_cnt_q;

  logic        accept;
  logic        load;
  logic        hold;
  logic        issue;
  logic [2:0]  nib_sel;
  logic [3:0]  nib;
  logic [1:0]  first_word_sel;
  logic [1:0]  next_word_sel;
  logic        unused_tb_bits;

  assign unused_tb_bits = ^tb_rdata[31:4];

  assign accept = (state_q == StIdle) && line_start && (32'(line_num) < LINES);
  assign load   = b_vld_q && (!pix_valid || pix_ready);
  // While the output is stalled the palette address is held so pal_rdata stays valid.
  assign hold   = b_vld_q && !load;
  assign issue  = (state_q == StPix) && !hold;

`ifdef TILE_HFLIP_EN
  logic flip_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flip_q <= 1'b0;
    end else if (state_q == StTbData) begin
      flip_q <= tb_rdata[4];
    end
  end

  assign nib_sel        = flip_q ? ~nib_idx_q : nib_idx_q;
  assign first_word_sel = tb_rdata[4] ? 2'd3 : 2'd0;
  assign next_word_sel  = flip_q ? ~(word_idx_q + 2'd1) : (word_idx_q + 2'd1);
`else
  assign nib_sel        = nib_idx_q;
  assign first_word_sel = 2'd0;
  assign next_word_sel  = word_idx_q + 2'd1;
`endif

  assign nib      = word_q[{nib_sel, 2'b00} +: 4];
  assign pal_addr = hold ? b_addr_q : nib[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      tb_addr    <= '0;
      tg_addr    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      word_idx_q <= '0;
      tile_id_q  <= '0;
      word_q     <= '0;
      nib_idx_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StTbAddr;
            busy       <= 1'b1;
            tb_addr    <= 9'(32'(line_num[8:5]) * TILES_X);
            row_q      <= line_num[4:0];
            col_q      <= '0;
            word_idx_q <= '0;
          end
        end
        StTbAddr: state_q <= StTbData;
        StTbData: begin
          tile_id_q <= tb_rdata[3:0];
          tg_addr   <= {tb_rdata[3:0], row_q, first_word_sel};
          state_q   <= StTgAddr;
        end
        StTgAddr: state_q <= StTgData;
        StTgData: begin
          word_q    <= tg_rdata;
          nib_idx_q <= '0;
          state_q   <= StPix;
        end
        StPix: begin
          if (issue) begin
            nib_idx_q <= nib_idx_q + 3'd1;
            if (nib_idx_q == 3'd7) begin
              if (word_idx_q != 2'd3) begin
                word_idx_q <= word_idx_q + 2'd1;
                tg_addr    <= {tile_id_q, row_q, next_word_sel};
                state_q    <= StTgAddr;
              end else if (col_q != 5'(TILES_X - 1)) begin
                col_q      <= col_q + 5'd1;
                tb_addr    <= tb_addr + 9'd1;
                word_idx_q <= '0;
                state_q    <= StTbAddr;
              end else begin
                state_q <= StDrain;
              end
            end
          end
        end
        StDrain: begin
          if (pix_valid && pix_ready && pix_last) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_vld_q    <= 1'b0;
      b_addr_q   <= '0;
      b_transp_q <= 1'b0;
      out_cnt_q  <= '0;
      pix_valid  <= 1'b0;
      pix_rgb    <= '0;
      pix_x      <= '0;
      pix_transp <= 1'b0;
      pix_last   <= 1'b0;
    end else begin
      if (!hold) begin
        b_vld_q <= issue;
        if (issue) begin
          b_addr_q   <= nib[2:0];
          b_transp_q <= nib[3];
        end
      end
      if (accept) begin
        out_cnt_q <= '0;
      end
      if (load) begin
        pix_valid  <= 1'b1;
        pix_rgb    <= pal_rdata;
        pix_x      <= out_cnt_q;
        pix_transp <= b_transp_q;
        pix_last   <= (out_cnt_q == 10'(LastX));
        out_cnt_q  <= out_cnt_q + 10'd1;
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
        pix_last  <= 1'b0;
      end
    end
  end

endmodule
